// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the PC, reads the instruction ROM and buffers {pc, inst} in a prefetch FIFO for decode.
// Optional perf counters (fetch_cnt_o, stall_cnt_o) are enabled with FETCH_PERF_CNT_EN.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q   [FQ_DEPTH];
    logic [31:0]   inst_mem_q [FQ_DEPTH];

    logic push, pop, full;
    logic [1:0] unused_rpc_lo;

    assign unused_rpc_lo = redirect_pc_i[1:0];
    assign full          = (count_q == DEPTH_C);
    assign out_valid_o   = (count_q != '0);
    assign pop           = out_valid_o & out_ready_i;
    assign push          = !redirect_i & (!full | pop);
    assign inst_addr_o   = pc_q;
    assign out_inst_o    = out_valid_o ? inst_mem_q[rd_ptr_q] : 32'h0;
    assign out_pc_o      = out_valid_o ? pc_mem_q[rd_ptr_q]   : 32'h0;

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_i) begin
            // A same-cycle pop is consumed by decode but the flush discards the rest.
            pc_d     = {redirect_pc_i[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_mem_q[i]   <= 32'h0;
                inst_mem_q[i] <= 32'h0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= pc_q;
            inst_mem_q[wr_ptr_q] <= inst_i;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (push && fetch_cnt_q != 32'hFFFF_FFFF) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (full && !pop && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: hand-derived vector table plus a queue-based reference model of the FIFO.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] inst_addr, inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_inst, out_pc;

    logic [31:0] inst_addr2, inst2, out_inst2, out_pc2;
    logic        out_valid2;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic        out_ready2 = 1'b1;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt, fetch_cnt2, stall_cnt2;
    logic [31:0] m_fetch, m_stall;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    assign inst  = rom(inst_addr);
    assign inst2 = rom(inst_addr2);

    inst_fetch_queue #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .inst_addr_o(inst_addr), .inst_i(inst),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_inst_o(out_inst), .out_pc_o(out_pc)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt)
`endif
    );

    inst_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rstn(rstn), .inst_addr_o(inst_addr2), .inst_i(inst2),
        .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready2),
        .out_inst_o(out_inst2), .out_pc_o(out_pc2)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt_o(fetch_cnt2), .stall_cnt_o(stall_cnt2)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    int          n_tot  = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Called at a negedge: drive inputs, compare against the model, advance the model, move to next negedge.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic m_pop, m_push;
        out_ready   = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        chk("inst_addr", inst_addr, m_pc);
        chk("out_valid", {31'h0, out_valid}, {31'h0, q.size() != 0});
        chk("out_pc",   out_pc,   (q.size() != 0) ? q[0].pc   : 32'h0);
        chk("out_inst", out_inst, (q.size() != 0) ? q[0].inst : 32'h0);
        m_pop  = (q.size() != 0) && rdy;
        m_push = !redir && ((q.size() < DEPTH) || m_pop);
`ifdef FETCH_PERF_CNT_EN
        if (m_push) m_fetch++;
        if (q.size() == DEPTH && !m_pop) m_stall++;
`endif
        if (redir) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back('{pc: m_pc, inst: rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vt[12];

    initial begin
        vt[0]  = '{1'b1, 1'b0, 32'h0,   32'h00, 1'b0, 32'h00};
        vt[1]  = '{1'b1, 1'b0, 32'h0,   32'h04, 1'b1, 32'h00};
        vt[2]  = '{1'b1, 1'b0, 32'h0,   32'h08, 1'b1, 32'h04};
        vt[3]  = '{1'b0, 1'b0, 32'h0,   32'h0C, 1'b1, 32'h08};
        vt[4]  = '{1'b0, 1'b0, 32'h0,   32'h10, 1'b1, 32'h08};
        vt[5]  = '{1'b0, 1'b0, 32'h0,   32'h14, 1'b1, 32'h08};
        vt[6]  = '{1'b0, 1'b0, 32'h0,   32'h18, 1'b1, 32'h08};
        vt[7]  = '{1'b1, 1'b0, 32'h0,   32'h18, 1'b1, 32'h08};
        vt[8]  = '{1'b0, 1'b0, 32'h0,   32'h1C, 1'b1, 32'h0C};
        vt[9]  = '{1'b0, 1'b1, 32'h103, 32'h1C, 1'b1, 32'h0C};
        vt[10] = '{1'b1, 1'b0, 32'h0,   32'h100, 1'b0, 32'h00};
        vt[11] = '{1'b1, 1'b0, 32'h0,   32'h104, 1'b1, 32'h100};

        rstn = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        m_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
        m_fetch = 0; m_stall = 0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr",  inst_addr, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_pc",    out_pc, 32'h0);
        chk("rst_inst",  out_inst, 32'h0);
        chk("rst_addr2", inst_addr2, 32'hFFFF_FFF8);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            chk($sformatf("vec%0d_addr", i), inst_addr, vt[i].exp_addr);
            chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, {31'h0, vt[i].exp_valid});
            chk($sformatf("vec%0d_pc", i), out_pc, vt[i].exp_pc);
            if (i < 3) chk($sformatf("wrap_addr%0d", i), inst_addr2, 32'hFFFF_FFF8 + 32'(4 * i));
            if (i == 2) chk("wrap_outpc", out_pc2, 32'hFFFF_FFFC);
            cycle(vt[i].rdy, vt[i].redir, vt[i].rpc);
        end

        // long stall then drain with no gap
        cycle(1'b1, 1'b1, 32'h0);
        repeat (10) cycle(1'b0, 1'b0, 32'h0);
        chk("stall_addr_hold", inst_addr, 32'h10);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // redirect with 3 entries queued
        cycle(1'b0, 1'b1, 32'h0);
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0000_0103);
        chk("redir_valid", {31'h0, out_valid}, 32'h0);
        chk("redir_addr",  inst_addr, 32'h100);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_first_pc", out_pc, 32'h100);

        // back-to-back redirects, redirect with same-cycle pop, wrap through redirect
        cycle(1'b1, 1'b1, 32'h200);
        cycle(1'b1, 1'b1, 32'h302);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFF9);
        repeat (5) cycle(1'b1, 1'b0, 32'h0);

        // random traffic
        for (int i = 0; i < 200; i++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), $urandom);

`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, m_fetch);
        chk("stall_cnt", stall_cnt, m_stall);
`endif

        // async reset mid-burst with FIFO half full
        cycle(1'b0, 1'b1, 32'h40);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_addr",  inst_addr, 32'h0);
        chk("arst_pc",    out_pc, 32'h0);
        chk("arst_addr2", inst_addr2, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_CNT_EN
        chk("arst_fetch_cnt", fetch_cnt, 32'h0);
        chk("arst_stall_cnt", stall_cnt, 32'h0);
        m_fetch = 0; m_stall = 0;
`endif
        q.delete();
        m_pc = 32'h0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Fetch stage sitting directly upstream of the instruction ROM and feeding the decode stage.
- Owns the PC and drives the ROM address. Captures the combinationally returned instruction word into a small prefetch FIFO.
- Presents {pc, inst} to decode over a valid/ready handshake. Handles branch/jump redirects by flushing the FIFO and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FQ_DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- inst_addr_o  out  32  byte address to instruction ROM; equals the PC register.
- inst_i  in  32  instruction word from ROM; combinational, valid in the same cycle as inst_addr_o.
- redirect_i  in  1  pulse: flush FIFO and load the new PC.
- redirect_pc_i  in  32  target PC, sampled when redirect_i=1.
- out_valid_o  out  1  head entry available.
- out_ready_i  in  1  decode accepts the head entry.
- out_inst_o  out  32  head instruction.
- out_pc_o  out  32  PC of the head instruction.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC; count = 0; read/write pointers = 0; all FIFO storage = 0.
  - out_valid_o = 0, out_inst_o = 0, out_pc_o = 0.
- inst_addr_o = pc at all times, including reset, so the ROM read is valid in every cycle.
- Per-cycle strobes:
  - pop = out_valid_o & out_ready_i.
  - push = !redirect_i & (count < FQ_DEPTH | pop).
  - Push and pop in the same cycle are allowed, including when full.
- On push (clock edge):
  - Write {pc, inst_i} at the write pointer; write pointer +1 mod FQ_DEPTH.
  - pc <= pc + 4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0).
- On pop: read pointer +1 mod FQ_DEPTH.
- Count: count <= count + push - pop; never exceeds FQ_DEPTH, never underflows.
- Full, no pop: push = 0, pc holds, ROM address holds.
- Outputs:
  - out_valid_o = (count != 0).
  - out_inst_o / out_pc_o = head entry when valid, forced to 0 when empty.
  - Outputs come from registers/storage only; no combinational path from inst_i or out_ready_i to the out_* ports.
- Latency: an instruction addressed in cycle N is presented at out_* from cycle N+1. With out_ready_i held at 1, throughput is 1 instruction/cycle.
- Redirect (takes priority over everything):
  - At the edge: count <= 0, both pointers <= 0.
  - pc <= {redirect_pc_i[31:2], 2'b00}; low 2 bits are always forced to zero.
  - No push that cycle. A same-cycle pop handshake is still counted as consumed by decode, but the entry is discarded by the flush.
  - Next cycle: out_valid_o = 0 and inst_addr_o = new pc. The first post-redirect instruction appears one cycle later.
- Back-to-back redirects: each one flushes; the last one wins.
- Reset mid-operation: everything returns to reset values immediately, asynchronously; in-flight entries are lost.
- Handshake rule: while out_valid_o = 1 and out_ready_i = 0, out_inst_o/out_pc_o are stable unless redirect_i flushes.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - fetch_cnt_o (out, 32): increments on every push.
  - stall_cnt_o (out, 32): increments every cycle with count == FQ_DEPTH and no pop.
- Both counters reset to 0 on rstn, saturate at 32'hFFFF_FFFF, and are not cleared by redirect.
- When not defined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, rstn released, out_ready_i=1, ROM returns addr-tagged words -> inst_addr_o sequence 0,4,8,...; out_valid_o high from the first edge after release; out_pc_o 0,4,8 on consecutive cycles with matching out_inst_o.
- out_ready_i=0 for 10 cycles -> count reaches 4 (pc=0x10 with FQ_DEPTH=4); inst_addr_o holds 0x10; head stays pc=0, stable. Raising ready drains 0,4,8,C, then 0x10 follows with no gap.
- Full FIFO with out_ready_i=1 for one cycle -> simultaneous push/pop; count stays 4; pc advances by 4; no entry lost or duplicated.
- redirect_i with redirect_pc_i=0x0000_0103 while 3 entries are queued -> next cycle out_valid_o=0 and inst_addr_o=0x100; the following cycle out_pc_o=0x100.
- RESET_PC=32'hFFFF_FFF8, free-running -> pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rstn asserted asynchronously mid-burst with FIFO half full -> out_valid_o=0 and inst_addr_o=RESET_PC immediately, without waiting for a clock edge. With FETCH_PERF_CNT_EN defined, both counters read 0.
